// File: rtl/updown_counter_mod.sv
// Parameterised up/down counter: wrap or saturate, load, clear,
// terminal-count pulse and sticky overflow flag.
// Ports: clk, reset (sync, active-high), enable, up_dn, load,
//   load_val[WIDTH], clear, ovf_clr -> count[WIDTH], tc, overflow.
module updown_counter_mod #(
  parameter int unsigned      WIDTH    = 4,
  parameter longint unsigned  MAX_VAL  = 15,
  parameter bit               SATURATE = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             up_dn,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             clear,
  input  logic             ovf_clr,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             overflow
);

  localparam logic [WIDTH-1:0] MAXV = MAX_VAL[WIDTH-1:0];
  localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);
  localparam logic [WIDTH-1:0] ZERO = '0;

  logic             at_lim;
  logic             lim_evt;
  logic [WIDTH-1:0] step;
  logic [WIDTH-1:0] clamped;

  // Boundary in the current direction; direction is never stored.
  always_comb begin
    at_lim = up_dn ? (count == MAXV) : (count == ZERO);
  end

  // Only an enabled step (not overridden by clear/load) is a limit event.
  always_comb begin
    lim_evt = enable & ~clear & ~load & at_lim;
  end

  always_comb begin
    step = count;
    if (up_dn) begin
      if (at_lim) step = SATURATE ? MAXV : ZERO;
      else        step = count + ONE;
    end else begin
      if (at_lim) step = SATURATE ? ZERO : MAXV;
      else        step = count - ONE;
    end
  end

  always_comb begin
    clamped = (load_val > MAXV) ? MAXV : load_val;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= ZERO;
      tc    <= 1'b0;
    end else if (clear) begin
      count <= ZERO;
      tc    <= 1'b0;
    end else if (load) begin
      count <= clamped;
      tc    <= 1'b0;
    end else if (enable) begin
      count <= step;
      tc    <= at_lim;
    end else begin
      tc    <= 1'b0;
    end
  end

  // A new limit event beats a simultaneous clear request.
  always_ff @(posedge clk) begin
    if (reset)        overflow <= 1'b0;
    else if (lim_evt) overflow <= 1'b1;
    else if (ovf_clr) overflow <= 1'b0;
  end

endmodule

// File: tb/tb_updown_counter_mod.sv
// Bench: two counters (mod-10 wrap, mod-16 saturate) driven in
// parallel and compared each cycle against an arithmetic model.
module tb_updown_counter_mod;

  logic       clk = 1'b0;
  logic       reset, enable, up_dn, load, clear, ovf_clr;
  logic [3:0] load_val;
  logic [3:0] cnt_w, cnt_s;
  logic       tc_w, tc_s, ov_w, ov_s;

  int compared = 0;
  int mismatched = 0;

  int mw, ms;
  bit tw, ow, ts, os;

  always #5 clk = ~clk;

  updown_counter_mod #(.WIDTH(4), .MAX_VAL(9), .SATURATE(1'b0)) dut_w (
    .clk(clk), .reset(reset), .enable(enable), .up_dn(up_dn),
    .load(load), .load_val(load_val), .clear(clear),
    .ovf_clr(ovf_clr), .count(cnt_w), .tc(tc_w), .overflow(ov_w)
  );

  updown_counter_mod #(.WIDTH(4), .MAX_VAL(15), .SATURATE(1'b1)) dut_s (
    .clk(clk), .reset(reset), .enable(enable), .up_dn(up_dn),
    .load(load), .load_val(load_val), .clear(clear),
    .ovf_clr(ovf_clr), .count(cnt_s), .tc(tc_s), .overflow(ov_s)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Counter as arithmetic on the range 0..mx.
  task automatic mdl(inout int c, inout bit t, inout bit o,
                     input int mx, input bit sat);
    int nxt;
    bit lim;
    if (reset) begin
      c = 0; t = 0; o = 0;
      return;
    end
    lim = enable && !clear && !load &&
          (up_dn ? (c + 1 > mx) : (c - 1 < 0));
    if (up_dn)
      nxt = sat ? ((c + 1 > mx) ? mx : c + 1) : (c + 1) % (mx + 1);
    else
      nxt = sat ? ((c - 1 < 0) ? 0 : c - 1) : (c - 1 + mx + 1) % (mx + 1);
    if (lim) o = 1;
    else if (ovf_clr) o = 0;
    t = lim;
    if (clear) c = 0;
    else if (load) c = (int'(load_val) > mx) ? mx : int'(load_val);
    else if (enable) c = nxt;
  endtask

  task automatic cyc(input bit r, input bit cl, input bit ld,
                     input int lv, input bit en, input bit ud,
                     input bit oc);
    reset = r; clear = cl; load = ld; load_val = 4'(lv);
    enable = en; up_dn = ud; ovf_clr = oc;
    @(posedge clk);
    mdl(mw, tw, ow, 9, 1'b0);
    mdl(ms, ts, os, 15, 1'b1);
    #1;
    chk("w_count", 32'(cnt_w), 32'(mw));
    chk("w_tc", 32'(tc_w), 32'(tw));
    chk("w_ovf", 32'(ov_w), 32'(ow));
    chk("s_count", 32'(cnt_s), 32'(ms));
    chk("s_tc", 32'(tc_s), 32'(ts));
    chk("s_ovf", 32'(ov_s), 32'(os));
  endtask

  initial begin
    mw = 0; ms = 0; tw = 0; ts = 0; ow = 0; os = 0;
    // 1: reset then count up 12
    cyc(1, 0, 0, 0, 0, 0, 0);
    chk("rst_count", 32'(cnt_w), 32'd0);
    chk("rst_tc", 32'(tc_w), 32'd0);
    chk("rst_ovf", 32'(ov_s), 32'd0);
    for (int i = 0; i < 12; i++) begin
      cyc(0, 0, 0, 0, 1, 1, 0);
      if (i == 9) chk("wrap_tc", 32'(tc_w), 32'd1);
    end
    chk("after12", 32'(cnt_w), 32'd2);
    chk("ovf_sticky", 32'(ov_w), 32'd1);
    // 2: load 3, count down 5, clamp load 14
    cyc(0, 0, 1, 3, 0, 0, 0);
    for (int i = 0; i < 5; i++) cyc(0, 0, 0, 0, 1, 0, 0);
    chk("down_wrap", 32'(cnt_w), 32'd8);
    cyc(0, 0, 1, 14, 1, 1, 0);
    chk("w_clamp", 32'(cnt_w), 32'd9);
    chk("s_load14", 32'(cnt_s), 32'd14);
    // 3: saturate at 15, then down 2
    cyc(0, 0, 1, 13, 0, 0, 0);
    for (int i = 0; i < 5; i++) cyc(0, 0, 0, 0, 1, 1, 0);
    chk("sat_hold", 32'(cnt_s), 32'd15);
    chk("sat_tc", 32'(tc_s), 32'd1);
    cyc(0, 0, 0, 0, 1, 0, 0);
    cyc(0, 0, 0, 0, 1, 0, 0);
    chk("sat_down", 32'(cnt_s), 32'd13);
    chk("sat_down_tc", 32'(tc_s), 32'd0);
    // 4: priority
    cyc(0, 0, 1, 5, 0, 0, 0);
    cyc(0, 1, 1, 7, 1, 1, 0);
    chk("clr_prio", 32'(cnt_w), 32'd0);
    cyc(0, 0, 1, 7, 1, 1, 0);
    chk("load_prio", 32'(cnt_s), 32'd7);
    // 5: overflow clear, then set beats clear
    cyc(0, 0, 0, 0, 0, 0, 1);
    chk("ovf_clr", 32'(ov_w), 32'd0);
    cyc(0, 0, 1, 9, 0, 0, 0);
    cyc(0, 0, 0, 0, 1, 1, 1);
    chk("ovf_set_wins", 32'(ov_w), 32'd1);
    // 6: reset mid-count, resume, hold
    cyc(0, 0, 1, 6, 0, 0, 0);
    cyc(1, 0, 0, 0, 1, 1, 0);
    chk("mid_rst", 32'(cnt_w), 32'd0);
    cyc(0, 0, 0, 0, 1, 1, 0);
    cyc(0, 0, 0, 0, 1, 1, 0);
    chk("resume", 32'(cnt_s), 32'd2);
    for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0, 0, 1, 0);
    chk("hold", 32'(cnt_w), 32'd2);
    // random traffic
    for (int i = 0; i < 400; i++) begin
      cyc($urandom_range(0, 49) == 0, $urandom_range(0, 24) == 0,
          $urandom_range(0, 11) == 0, int'($urandom_range(0, 15)),
          $urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0,
          $urandom_range(0, 9) == 0);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end

endmodule

// File: doc/updown_counter_mod.md
Name: updown_counter_mod

Overview:
Parameterised successor to the team's 4-bit enable counter. Adds:
- configurable width and modulus
- up/down direction
- synchronous parallel load and clear
- wrap or saturate mode
- registered terminal-count pulse and sticky overflow flag

Used as the general-purpose event/timebase counter in generated designs, e.g. decade counters and timer prescalers.

Parameters:
WIDTH, 4, counter width in bits (1..32)
MAX_VAL, 15, highest count value; legal range 1..2^WIDTH-1; count range is 0..MAX_VAL
SATURATE, 0, 0 = wrap at limits, 1 = hold at limits

Ports:
clk  input  1  system clock, rising edge
reset  input  1  synchronous, active-high reset
enable  input  1  count one step this cycle when high
up_dn  input  1  1 = count up, 0 = count down; sampled only when counting
load  input  1  synchronous parallel load strobe
load_val  input  WIDTH  value loaded when load=1
clear  input  1  synchronous clear to 0
ovf_clr  input  1  clears sticky overflow flag
count  output  WIDTH  current count, registered
tc  output  1  registered one-cycle terminal-count pulse
overflow  output  1  sticky limit-event flag, registered

Behaviour:
- All state updates on the rising edge of clk. All outputs are registered; there is no combinational input-to-output path.
- Reset (reset=1): count=0, tc=0, overflow=0. Reset overrides every other input and may occur mid-count.
- Priority per cycle: reset > clear > load > enable.
- Clear: count<=0, tc<=0. overflow is unaffected.
- Load: count<=min(load_val, MAX_VAL); values above MAX_VAL are clamped. tc<=0. overflow is unaffected. enable is ignored that cycle.
- enable=0 and no clear/load: count holds, tc<=0.
- Count step, enable=1, up_dn=1:
  - count<MAX_VAL: count+1.
  - count==MAX_VAL, SATURATE=0: count<=0 (wrap).
  - count==MAX_VAL, SATURATE=1: count holds at MAX_VAL.
- Count step, enable=1, up_dn=0:
  - count>0: count-1.
  - count==0, SATURATE=0: count<=MAX_VAL (wrap).
  - count==0, SATURATE=1: count holds at 0.
- Limit event: an enabled step taken while count is at the boundary in the current direction (MAX_VAL going up, 0 going down), in either mode.
- tc:
  - Goes high for exactly the one cycle after a limit event (registered alongside the new count).
  - Low otherwise.
  - Stays high for consecutive cycles while repeated limit events occur (saturate mode with enable held).
- overflow:
  - Set by a limit event.
  - Cleared by ovf_clr=1.
  - If set and ovf_clr coincide in the same cycle, set wins (overflow=1).
- up_dn may change on any cycle; direction takes effect on the same edge. No hidden direction state.
- Arithmetic is performed in WIDTH bits. The next-value comparison must never produce a value outside 0..MAX_VAL. When MAX_VAL=2^WIDTH-1, a natural binary wrap is acceptable.
- Out-of-range count is unreachable: load is clamped and reset/clear go to 0.

Test Plan:
1. WIDTH=4, MAX_VAL=9, SATURATE=0; reset 1 cycle, then enable=1, up_dn=1 for 12 cycles -> count 0,1,..,9,0,1,2. tc high only in the cycle count shows 0 after 9. overflow=1 from that cycle onward.
2. Same config; load=1, load_val=3, then up_dn=0, enable=1 for 5 cycles -> count 3,2,1,0,9,8. tc pulses with count=9. Then load_val=14 -> count=9 (clamped).
3. WIDTH=4, MAX_VAL=15, SATURATE=1; load 13, count up 5 cycles -> 14,15,15,15,15. tc high for the last 3 cycles. Then count down 2 -> 14,13 with tc=0.
4. Priority: count=5, assert clear, load (load_val=7) and enable together -> count=0. Then load and enable together (load_val=7) -> count=7, no increment.
5. overflow handling: after a wrap, assert ovf_clr alone -> overflow=0 next cycle. Then a limit event with ovf_clr=1 in the same cycle -> overflow=1.
6. Reset mid-count: count=6, enable=1, assert reset 1 cycle -> count=0, tc=0, overflow=0. Counting resumes 1,2,... after release. enable=0 for 3 cycles -> count holds.
